// File: rtl/ifu_bp_resolve_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_bp_resolve_ctl
//  Brief    : Fetch-side consumer of EXU branch resolution. Resolved-branch
//             BHT updates are queued in a small FIFO and drained into the BHT
//             write port when fetch is not reading it. A starvation counter
//             forces a write, and stalls fetch, if fetch holds the port too
//             long. The EXU redirect is held in a valid/ack handshake toward
//             the fetch PC mux, and flush_lower cancels it.
//  Options  : BP_MISP_CNT_EN - when defined, perf_misp_cnt counts accepted
//             mispredicted updates. When undefined it is tied to zero and
//             has no flops.
//  Revision : 1.0 - initial release
// ============================================================================
module ifu_bp_resolve_ctl #(
   parameter int BHT_AW     = 8,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 7
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              exu_upd_valid,
   input  logic              exu_upd_misp,
   input  logic [1:0]        exu_upd_hist,
   input  logic [BHT_AW-1:0] exu_upd_index,
   input  logic              exu_upd_way,
   input  logic              exu_flush_upper,
   input  logic [30:0]       exu_flush_path,
   input  logic              flush_lower,
   input  logic              ifu_fetch_rd,
   input  logic              ifu_redirect_ack,
   output logic              bht_wr_en,
   output logic [BHT_AW-1:0] bht_wr_addr,
   output logic              bht_wr_way,
   output logic [1:0]        bht_wr_data,
   output logic              ifu_bht_stall,
   output logic              ifu_redirect_valid,
   output logic [30:0]       ifu_redirect_pc,
   output logic              upd_full,
   output logic [7:0]        upd_drop_cnt,
   output logic [15:0]       perf_misp_cnt
);

   // Pointer index width; the pointers carry one extra wrap bit for full/empty.
   localparam int c_PW = $clog2(DEPTH);
   // One FIFO entry holds {index, way, hist}.
   localparam int c_EW = BHT_AW + 3;
   localparam int c_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);
   localparam logic [c_PW:0]   c_PTR_ONE    = (c_PW + 1)'(1);
   localparam logic [c_SW-1:0] c_STARVE_ONE = c_SW'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } redir_state_t;

   logic [c_EW-1:0] r_mem [DEPTH];
   logic [c_PW:0]   r_wr_ptr;
   logic [c_PW:0]   r_rd_ptr;
   logic [c_SW-1:0] r_starve_cnt;
   logic [7:0]      r_drop_cnt;
   redir_state_t    r_state;
   redir_state_t    w_state_nxt;
   logic [30:0]     r_redir_pc;
   logic [30:0]     w_redir_pc_nxt;

   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_drop;
   logic            w_starve_hit;
   logic [c_EW-1:0] w_push_entry;
   logic [c_EW-1:0] w_head;

   assign w_empty      = (r_wr_ptr == r_rd_ptr);
   assign w_full       = (r_wr_ptr[c_PW] != r_rd_ptr[c_PW]) &&
                         (r_wr_ptr[c_PW-1:0] == r_rd_ptr[c_PW-1:0]);
   assign w_starve_hit = (r_starve_cnt == c_STARVE_MAX);
   // A write happens whenever fetch leaves the port free, or when starved.
   assign w_pop        = ~w_empty & (~ifu_fetch_rd | w_starve_hit);
   // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
   assign w_push       = exu_upd_valid & (~w_full | w_pop);
   assign w_drop       = exu_upd_valid & w_full & ~w_pop;
   assign w_push_entry = {exu_upd_index, exu_upd_way, exu_upd_hist};
   assign w_head       = r_mem[r_rd_ptr[c_PW-1:0]];

   // Entry storage; contents are only observed while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_PW-1:0]] <= w_push_entry;
      end
   end

   // Read/write pointers advance on pop/push independently.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

   // Count consecutive cycles a pending update is blocked by fetch reads.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_starve_cnt <= '0;
      end else if (w_empty || w_pop) begin
         r_starve_cnt <= '0;
      end else if (ifu_fetch_rd) begin
         r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
      end
   end

   // Saturating count of updates lost to a full FIFO.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_drop_cnt <= 8'h00;
      end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'h01;
      end
   end

   // Redirect state and latched PC registers.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state    <= ST_IDLE;
         r_redir_pc <= 31'h0;
      end else begin
         r_state    <= w_state_nxt;
         r_redir_pc <= w_redir_pc_nxt;
      end
   end

   // Redirect next state: flush_lower wins, a new flush_upper re-latches even
   // in the same cycle as an ack, otherwise an ack retires the redirect.
   always_comb begin
      w_state_nxt    = r_state;
      w_redir_pc_nxt = r_redir_pc;
      case (r_state)
         ST_IDLE: begin
            if (exu_flush_upper && !flush_lower) begin
               w_state_nxt    = ST_PEND;
               w_redir_pc_nxt = exu_flush_path;
            end
         end
         ST_PEND: begin
            if (flush_lower) begin
               w_state_nxt = ST_IDLE;
            end else if (exu_flush_upper) begin
               w_state_nxt    = ST_PEND;
               w_redir_pc_nxt = exu_flush_path;
            end else if (ifu_redirect_ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

`ifdef BP_MISP_CNT_EN
   logic [15:0] r_misp_cnt;

   // Saturating count of accepted mispredicted updates.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_misp_cnt <= 16'h0000;
      end else if (w_push && exu_upd_misp && (r_misp_cnt != 16'hFFFF)) begin
         r_misp_cnt <= r_misp_cnt + 16'h0001;
      end
   end

   assign perf_misp_cnt = r_misp_cnt;
`else
   logic w_unused_misp;
   assign w_unused_misp = exu_upd_misp;
   assign perf_misp_cnt = 16'h0000;
`endif

   // Head fields are masked while empty so the port reads zero when idle.
   assign bht_wr_en          = w_pop;
   assign bht_wr_addr        = w_empty ? '0   : w_head[c_EW-1:3];
   assign bht_wr_way         = w_empty ? 1'b0 : w_head[2];
   assign bht_wr_data        = w_empty ? 2'b0 : w_head[1:0];
   assign ifu_bht_stall      = w_starve_hit & ~w_empty & ifu_fetch_rd;
   assign ifu_redirect_valid = (r_state == ST_PEND);
   assign ifu_redirect_pc    = r_redir_pc;
   assign upd_full           = w_full;
   assign upd_drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire
